router_port_drain: RTL and testbench

//  Output-side consumer for one port of the 1x4 router. It watches vld_out and pulls bytes out of the router's port

---
 rtl/router_port_drain_if.sv | 25 ++
 rtl/router_port_drain.sv | 177 +++++++++++++++++
 tb/tb_router_port_drain.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_port_drain_if.sv
// Byte stream from the port drain to the local sink.
// A byte is transferred on every rising clk edge where m_valid and m_ready are both 1.
// m_data and m_last are held stable while m_valid=1 and m_ready=0.
interface router_port_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/router_port_drain.sv
// Drains one router output FIFO into a valid/ready byte stream.
// Re-frames each packet and checks its parity and destination address.
module router_port_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int PORT_ID    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  vld_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_enb,
    router_port_drain_if.master   m_if,
    output logic                  pkt_done,
    output logic                  parity_err,
    output logic                  addr_err,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLD  = 2'd1,
        S_PAR  = 2'd2
    } state_e;

    localparam logic [1:0] MY_ADDR = 2'(PORT_ID);

    // Read side
    logic rd_fire;
    logic rd_fire_q, rd_fire_d;
    logic rx;

    // Skid buffer: entries hold {last, byte}
    logic [DATA_WIDTH:0] skid_q [2];
    logic [DATA_WIDTH:0] skid_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          occ_q, occ_d;
    logic                push, pop;
    logic                rx_last;

    // Packet FSM
    state_e               state_q, state_d;
    logic [5:0]           rem_q, rem_d;
    logic [1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] par_q, par_d;

    // Status
    logic             pkt_done_q, pkt_done_d;
    logic             parity_err_q, parity_err_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Occupancy plus in-flight read bounds the skid at 2 entries without
    // looking at m_ready, so read_enb never depends on the sink.
    always_comb begin
        read_enb = resetn & vld_out &
                   (({1'b0, occ_q} + {2'b00, rd_fire_q}) < 3'd2);
        rd_fire   = read_enb & vld_out;
        rd_fire_d = rd_fire;
        rx        = rd_fire_q;
    end

    always_comb begin
        rx_last = (state_q == S_PAR);
        push    = rx;
        pop     = (occ_q != 2'd0) & m_if.m_ready;

        skid_d[0] = skid_q[0];
        skid_d[1] = skid_q[1];
        if (push) begin
            skid_d[wr_ptr_q] = {rx_last, data_out};
        end

        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + 2'(push) - 2'(pop);
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        addr_d       = addr_q;
        par_d        = par_q;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        addr_err_d   = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (rx) begin
            case (state_q)
                S_IDLE: begin
                    rem_d   = data_out[7:2];
                    addr_d  = data_out[1:0];
                    par_d   = data_out;
                    state_d = (data_out[7:2] != 6'd0) ? S_PLD : S_PAR;
                end
                S_PLD: begin
                    par_d = par_q ^ data_out;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d = S_PAR;
                    end
                end
                S_PAR: begin
                    pkt_done_d   = 1'b1;
                    parity_err_d = (par_q != data_out);
                    addr_err_d   = (addr_q != MY_ADDR);
                    state_d      = S_IDLE;
                    if (pkt_cnt_q != {CNT_W{1'b1}}) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end
                    if (((par_q != data_out) || (addr_q != MY_ADDR)) &&
                        (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_fire_q    <= 1'b0;
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            state_q      <= S_IDLE;
            rem_q        <= 6'd0;
            addr_q       <= 2'd0;
            par_q        <= '0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            rd_fire_q    <= rd_fire_d;
            skid_q[0]    <= skid_d[0];
            skid_q[1]    <= skid_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            par_q        <= par_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            addr_err_q   <= addr_err_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        m_if.m_data  = skid_q[rd_ptr_q][DATA_WIDTH-1:0];
        m_if.m_last  = skid_q[rd_ptr_q][DATA_WIDTH] & (occ_q != 2'd0);
        m_if.m_valid = (occ_q != 2'd0);
        pkt_done     = pkt_done_q;
        parity_err   = parity_err_q;
        addr_err     = addr_err_q;
        pkt_cnt      = pkt_cnt_q;
        err_cnt      = err_cnt_q;
        state_dbg    = state_q;
    end

endmodule

// File: tb/tb_router_port_drain.sv
// Directed bench for router_port_drain (PORT_ID=2): a router FIFO model feeds
// bytes, a monitor pops expected bytes/status from queues and compares.
module tb_router_port_drain;

  logic        clk = 1'b0;
  logic        resetn;
  logic        vld_out;
  logic [7:0]  data_out;
  logic        read_enb;
  logic        pkt_done;
  logic        parity_err;
  logic        addr_err;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [1:0]  state_dbg;

  router_port_drain_if #(.DATA_WIDTH(8)) m_if ();

  router_port_drain #(
    .DATA_WIDTH(8),
    .PORT_ID   (2),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .read_enb  (read_enb),
    .m_if      (m_if),
    .pkt_done  (pkt_done),
    .parity_err(parity_err),
    .addr_err  (addr_err),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [7:0] src_q[$];
  logic [8:0] exp_q[$];
  logic [1:0] stat_q[$];
  logic [7:0] pkt_b[$];
  int         total = 0;
  int         bad   = 0;
  bit         chk_en = 1'b1;
  bit         fire_s = 1'b0;
  bit         gap = 1'b0;
  bit         toggle = 1'b0;
  int         stall_cnt = 0;
  int         fired = 0;
  int         fwd = 0;
  int         max_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic load_pkt(input logic perr, input logic aerr);
    for (int i = 0; i < pkt_b.size(); i++) begin
      src_q.push_back(pkt_b[i]);
      exp_q.push_back({(i == pkt_b.size() - 1), pkt_b[i]});
    end
    stat_q.push_back({perr, aerr});
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (src_q.size() == 0 && exp_q.size() == 0 && stat_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_fired(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (fired >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk("fired_reached", 32'(ok), 32'd1);
  endtask

  // router FIFO model and sink ready pattern, driven just after the edge
  always @(posedge clk) begin
    #1;
    if (fire_s && src_q.size() != 0) data_out = src_q.pop_front();
    vld_out = (src_q.size() != 0) && !gap;
    if (stall_cnt > 0) begin
      m_if.m_ready = 1'b0;
      stall_cnt--;
    end else if (toggle) begin
      m_if.m_ready = ~m_if.m_ready;
    end else begin
      m_if.m_ready = 1'b1;
    end
  end

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    int         outst;
    logic [8:0] e;
    logic [1:0] s;
    if (!resetn) begin
      fired  = 0;
      fwd    = 0;
      fire_s = 1'b0;
    end else begin
      outst = fired - fwd;
      if (outst > max_out) max_out = outst;
      if (vld_out) chk("read_enb", 32'(read_enb), 32'(outst < 2));
      fire_s = read_enb && vld_out;
      if (fire_s) fired++;
      if (m_if.m_valid && m_if.m_ready) begin
        fwd++;
        if (chk_en) begin
          if (exp_q.size() == 0) chk("unexpected_byte", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("m_byte", {23'd0, m_if.m_last, m_if.m_data}, {23'd0, e});
          end
        end
      end
      if (pkt_done) begin
        if (stat_q.size() == 0) chk("unexpected_pkt_done", 32'd1, 32'd0);
        else begin
          s = stat_q.pop_front();
          chk("parity_err", 32'(parity_err), 32'(s[1]));
          chk("addr_err", 32'(addr_err), 32'(s[0]));
        end
      end else begin
        chk("err_idle", {30'd0, parity_err, addr_err}, 32'd0);
      end
    end
  end

  initial begin
    int         base;
    logic [7:0] p;
    resetn       = 1'b0;
    vld_out      = 1'b0;
    data_out     = 8'h00;
    m_if.m_ready = 1'b1;

    // 1: reset with data pending; len=3 addr=2, parity 0E^A5^3C^A7 = 30
    pkt_b = '{8'h0E, 8'hA5, 8'h3C, 8'hA7, 8'h30};
    load_pkt(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_enb", 32'(read_enb), 32'd0);
    chk("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("read_enb_after_rst", 32'(read_enb), 32'd1);

    // 2: good packet
    wait_idle(200);
    chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd0);

    // 3: bad parity byte, then wrong address (0D^A5^3C^A7 = 33)
    pkt_b = '{8'h0E, 8'hA5, 8'h3C, 8'hA7, 8'h00};
    load_pkt(1'b1, 1'b0);
    pkt_b = '{8'h0D, 8'hA5, 8'h3C, 8'hA7, 8'h33};
    load_pkt(1'b0, 1'b1);
    wait_idle(200);
    chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd3);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);

    // 4: 63-byte payload under toggling ready with a 3-cycle stall
    pkt_b.delete();
    pkt_b.push_back(8'hFE);
    p = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pkt_b.push_back(8'(i * 7 + 3));
      p = p ^ 8'(i * 7 + 3);
    end
    pkt_b.push_back(p);
    toggle = 1'b1;
    base = fired;
    load_pkt(1'b0, 1'b0);
    wait_fired(base + 32, 500);
    stall_cnt = 3;
    wait_idle(1000);
    toggle = 1'b0;
    chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd4);
    chk("t4_err_cnt", 32'(err_cnt), 32'd2);

    // 5: two zero-length packets back to back, then a gap mid-payload
    base = fired;
    pkt_b = '{8'h02, 8'h02};
    load_pkt(1'b0, 1'b0);
    load_pkt(1'b0, 1'b0);
    // len=4 addr=2: 12^11^22^33^44 = 56
    pkt_b = '{8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    load_pkt(1'b0, 1'b0);
    wait_fired(base + 6, 200);
    gap = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_state_hold", 32'(state_dbg), 32'd1);
    chk("t5_mid_pkt_cnt", 32'(pkt_cnt), 32'd6);
    gap = 1'b0;
    wait_idle(200);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd7);
    chk("t5_err_cnt", 32'(err_cnt), 32'd2);

    // 6: reset after 2 payload bytes, then a fresh good packet
    chk_en = 1'b0;
    base = fired;
    pkt_b = '{8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    foreach (pkt_b[i]) src_q.push_back(pkt_b[i]);
    wait_fired(base + 3, 200);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    src_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("t6_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    pkt_b = '{8'h0E, 8'hA5, 8'h3C, 8'hA7, 8'h30};
    load_pkt(1'b0, 1'b0);
    wait_idle(200);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);

    // final report
    chk("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("stat_q_empty", 32'(stat_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
